// File: rtl/mem_ctrl.sv
// mem_ctrl: pipelined data memory with clear-on-reset, byte-enable writes and LATENCY-cycle read return.
// Define MEM_OOB_TRAP_EN to trap Addr >= DEPTH (write suppressed, DOut = 0, sticky MemOOB).
module mem_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                    CLK,
    input  logic                    ResetN,
    input  logic                    Req,
    input  logic                    WriteEnable,
    input  logic [ADDR_WIDTH-1:0]   Addr,
    input  logic [DATA_WIDTH-1:0]   DIn,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic                    OOBClear,
    output logic                    Ready,
    output logic                    Valid,
    output logic [DATA_WIDTH-1:0]   DOut,
    output logic                    MemOOB
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state, state_d;
    logic [AW-1:0]         cnt, cnt_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd, merged, res;
    logic [AW-1:0]         idx;
    logic                  acc, bad, wr;
    logic [LATENCY-1:0]    vld;
    logic [DATA_WIDTH-1:0] dat [LATENCY];
    logic                  unused_ok;

    assign idx   = Addr[AW-1:0];
    assign Ready = (state == RUN);
    assign acc   = Req && Ready;
    assign wr    = acc && WriteEnable && !bad;
    assign Valid = vld[LATENCY-1];
    assign DOut  = dat[LATENCY-1];

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (state == INIT) begin
            cnt_d = cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1))
                state_d = RUN;
        end
    end

    // Write-first: the returned word is the one committed at the accept edge.
    always_comb begin
        rd     = mem[idx];
        merged = rd;
        for (int i = 0; i < NB; i++)
            if (ByteEn[i])
                merged[8*i+:8] = DIn[8*i+:8];
        res = bad ? '0 : WriteEnable ? merged : rd;
    end

    always_ff @(posedge CLK) begin
        if (state == INIT)
            mem[cnt] <= '0;
        else if (wr)
            mem[idx] <= merged;
    end

    // Stage data only moves with a valid entry, so DOut holds across bubbles.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++)
                dat[i] <= '0;
        end else begin
            vld[0] <= acc;
            if (acc)
                dat[0] <= res;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1])
                    dat[i] <= dat[i-1];
            end
        end
    end

`ifdef MEM_OOB_TRAP_EN
    logic [LATENCY-1:0] oob;
    logic               oob_in;

    assign bad       = {1'b0, Addr} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign oob_in    = (LATENCY == 1) ? (acc && bad) : oob[LATENCY > 1 ? LATENCY - 2 : 0];
    assign unused_ok = oob[LATENCY-1];

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            oob    <= '0;
            MemOOB <= 1'b0;
        end else begin
            oob[0] <= acc && bad;
            for (int i = 1; i < LATENCY; i++)
                oob[i] <= oob[i-1];
            MemOOB <= oob_in ? 1'b1 : OOBClear ? 1'b0 : MemOOB;
        end
    end
`else
    assign bad       = 1'b0;
    assign MemOOB    = 1'b0;
    assign unused_ok = ^{OOBClear, Addr[ADDR_WIDTH-1:AW]};
`endif
endmodule
